// File: rtl/reloj_pkg.sv
// reloj_pkg: mode/field constants, BCD limits and BCD increment helper for the digital clock
package reloj_pkg;
  localparam int MODO_RELOJ = 0;
  localparam int MODO_AJUSTE = 1;
  localparam int MODO_ALARMA0 = 2;
  typedef enum logic [1:0] {CAMPO_MIN, CAMPO_HOR, CAMPO_HAB} campo_t;
  localparam logic [7:0] BCD_MAX_MIN = 8'h59;
  localparam logic [7:0] BCD_MAX_HOR = 8'h23;
  function automatic logic [7:0] bcd_inc(input logic [7:0] value, input logic [7:0] max);
    return value == max ? 8'h00 : value[3:0] == 4'd9 ? {value[7:4] + 4'd1, 4'd0} : value + 8'd1;
  endfunction
endpackage

// File: rtl/contador_bcd_mod.sv
// contador_bcd_mod: two-digit BCD counter wrapping at MAX, with clear and carry-out
module contador_bcd_mod import reloj_pkg::*; #(
  parameter int W = 7,
  parameter logic [7:0] MAX = BCD_MAX_MIN
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q,
  output logic         carry
);
  assign carry = inc && q == W'(MAX);
  always_ff @(posedge clk)
    q <= rst || clr ? '0 : inc ? W'(bcd_inc(8'(q), MAX)) : q;
endmodule

// File: rtl/reloj_digital_param.sv
// reloj_digital_param: 24 h BCD clock with NUM_ALARMS alarms and edit FSM; define RELOJ_SNOOZE_EN for snooze
module reloj_digital_param import reloj_pkg::*; #(
  parameter int CLK_HZ = 50_000_000,
  parameter int NUM_ALARMS = 2,
  parameter int SNOOZE_MIN = 5
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              impulsoModo,
  input  logic                              impulsoAumentar,
  input  logic                              impulsoDisplay,
  output logic [$clog2(NUM_ALARMS+2)-1:0]   modo,
  output logic [1:0]                        campo,
  output logic [5:0]                        horasVista,
  output logic [6:0]                        minutosVista,
  output logic [6:0]                        segundos,
  output logic [NUM_ALARMS-1:0]             habilitada,
  output logic [NUM_ALARMS-1:0]             sonando,
  output logic                              parpadeo
);
  localparam int MW = $clog2(NUM_ALARMS+2);
  localparam int PW = $clog2(CLK_HZ);
  localparam logic [MW-1:0] M_RELOJ = MW'(MODO_RELOJ);
  localparam logic [MW-1:0] M_AJ = MW'(MODO_AJUSTE);
  localparam logic [MW-1:0] M_ULT = MW'(NUM_ALARMS + 1);
  logic [PW-1:0] pres;
  logic [5:0] hor, nhor;
  logic [6:0] mn, nmin;
  logic [6:0] amin [NUM_ALARMS];
  logic [5:0] ahor [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] match, hab_t, snz_set, unused_amin_c, unused_ahor_c;
  logic en_aj, aum, dsp, sil, tick, sec_c, min_c, unused_hor_c;
  assign en_aj = modo == M_AJ;
  assign aum = impulsoAumentar && !impulsoModo;
  assign dsp = impulsoDisplay && !impulsoModo;
  assign sil = aum && modo == M_RELOJ;
  assign tick = !en_aj && pres == PW'(CLK_HZ - 1);
  // match compares against the HH:MM the time is about to roll into
  assign nmin = 7'(bcd_inc(8'(mn), BCD_MAX_MIN));
  assign nhor = mn == 7'h59 ? 6'(bcd_inc(8'(hor), BCD_MAX_HOR)) : hor;
  always_ff @(posedge clock) begin
    pres <= reset || en_aj || pres == PW'(CLK_HZ - 1) ? '0 : pres + 1'b1;
    parpadeo <= reset ? 1'b0 : parpadeo ^ (!en_aj && (pres == PW'(CLK_HZ/2 - 1) || pres == PW'(CLK_HZ - 1)));
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      modo <= M_RELOJ;
      campo <= CAMPO_MIN;
    end else if (impulsoModo) begin
      modo <= modo == M_ULT ? '0 : modo + 1'b1;
      campo <= CAMPO_MIN;
    end else if (dsp && en_aj)
      campo <= campo == CAMPO_MIN ? CAMPO_HOR : CAMPO_MIN;
    else if (dsp && modo > M_AJ)
      campo <= campo == CAMPO_HAB ? CAMPO_MIN : campo + 2'd1;
  end
  contador_bcd_mod #(.W(7), .MAX(BCD_MAX_MIN)) u_seg (
    .clk(clock), .rst(reset), .inc(tick), .clr(en_aj), .q(segundos), .carry(sec_c));
  contador_bcd_mod #(.W(7), .MAX(BCD_MAX_MIN)) u_min (
    .clk(clock), .rst(reset), .inc(sec_c || (en_aj && aum && campo == CAMPO_MIN)), .clr(1'b0),
    .q(mn), .carry(min_c));
  contador_bcd_mod #(.W(6), .MAX(BCD_MAX_HOR)) u_hor (
    .clk(clock), .rst(reset), .inc((sec_c && min_c) || (en_aj && aum && campo == CAMPO_HOR)), .clr(1'b0),
    .q(hor), .carry(unused_hor_c));
  for (genvar k = 0; k < NUM_ALARMS; k++) begin : g_al
    logic ed;
    assign ed = aum && modo == MW'(MODO_ALARMA0 + k);
    contador_bcd_mod #(.W(7), .MAX(BCD_MAX_MIN)) u_amin (
      .clk(clock), .rst(reset), .inc(ed && campo == CAMPO_MIN), .clr(1'b0),
      .q(amin[k]), .carry(unused_amin_c[k]));
    contador_bcd_mod #(.W(6), .MAX(BCD_MAX_HOR)) u_ahor (
      .clk(clock), .rst(reset), .inc(ed && campo == CAMPO_HOR), .clr(1'b0),
      .q(ahor[k]), .carry(unused_ahor_c[k]));
    assign hab_t[k] = ed && campo == CAMPO_HAB;
    assign match[k] = sec_c && habilitada[k] && nmin == amin[k] && nhor == ahor[k];
  end
`ifdef RELOJ_SNOOZE_EN
  logic [NUM_ALARMS-1:0] mask;
  logic [5:0] snz;
  assign snz_set = sec_c && snz == 6'd1 ? mask & habilitada : '0;
  always_ff @(posedge clock) begin
    if (reset) begin
      mask <= '0;
      snz <= '0;
    end else if (sil && |sonando) begin
      mask <= sonando;
      snz <= 6'(SNOOZE_MIN);
    end else begin
      snz <= sec_c && snz != '0 ? snz - 6'd1 : snz;
      mask <= sec_c && snz == 6'd1 ? '0 : mask & ~(hab_t & habilitada);
    end
  end
`else
  localparam int unused_snooze = SNOOZE_MIN;
  assign snz_set = '0;
`endif
  // minute rollover reloads sonando from fresh matches, so a ring lasts one minute
  always_ff @(posedge clock) begin
    habilitada <= reset ? '0 : habilitada ^ hab_t;
    sonando <= reset ? '0 : {NUM_ALARMS{!sil}} & ~(hab_t & habilitada) & (sec_c ? match | snz_set : sonando);
  end
  always_comb begin
    horasVista = hor;
    minutosVista = mn;
    for (int i = 0; i < NUM_ALARMS; i++)
      if (modo == MW'(MODO_ALARMA0 + i)) begin
        horasVista = ahor[i];
        minutosVista = amin[i];
      end
  end
endmodule

// File: tb/tb_reloj_digital_param.sv
// tb_reloj_digital_param: table vectors, directed ring/snooze/rollover sequences and a random run vs a seconds-of-day model
module tb_reloj_digital_param;
  localparam int CLK = 4;
  localparam int NA = 2;
  localparam int SNZ = 2;
`ifdef RELOJ_SNOOZE_EN
  localparam logic [1:0] SNZ_EXP = 2'b10;
`else
  localparam logic [1:0] SNZ_EXP = 2'b00;
`endif
  logic clock = 0, reset = 1, impulsoModo = 0, impulsoAumentar = 0, impulsoDisplay = 0;
  logic [1:0] modo, campo;
  logic [5:0] horasVista;
  logic [6:0] minutosVista, segundos;
  logic [NA-1:0] habilitada, sonando;
  logic parpadeo;
  int vectors = 0, misc = 0;

  reloj_digital_param #(.CLK_HZ(CLK), .NUM_ALARMS(NA), .SNOOZE_MIN(SNZ)) dut (
    .clock(clock), .reset(reset), .impulsoModo(impulsoModo), .impulsoAumentar(impulsoAumentar),
    .impulsoDisplay(impulsoDisplay), .modo(modo), .campo(campo), .horasVista(horasVista),
    .minutosVista(minutosVista), .segundos(segundos), .habilitada(habilitada), .sonando(sonando),
    .parpadeo(parpadeo));

  always #5 clock = ~clock;

  logic [31:0] obs;
  assign obs = 32'({modo, campo, horasVista, minutosVista, segundos, habilitada, sonando, parpadeo});

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      misc++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: time as seconds of day, alarms as minutes of day
  int m_t, m_pres, m_mode, m_campo, m_snz;
  int al [NA];
  bit m_par;
  bit [NA-1:0] m_hab, m_son, m_mask;

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + v % 10);
  endfunction

  function automatic logic [31:0] expv();
    int h, mi;
    h = m_t / 3600;
    mi = m_t / 60 % 60;
    if (m_mode >= 2) begin
      h = al[m_mode-2] / 60;
      mi = al[m_mode-2] % 60;
    end
    return 32'({2'(m_mode), 2'(m_campo), 6'(bcd(h)), 7'(bcd(mi)), 7'(bcd(m_t % 60)), m_hab, m_son, m_par});
  endfunction

  always @(posedge clock) begin
    bit tk, rol, sil, m, a, d;
    bit [NA-1:0] mt, dis, re;
    if (reset) begin
      m_t = 0; m_pres = 0; m_mode = 0; m_campo = 0; m_snz = 0;
      m_par = 0; m_hab = 0; m_son = 0; m_mask = 0;
      for (int k = 0; k < NA; k++) al[k] = 0;
    end else begin
      m = impulsoModo;
      a = impulsoAumentar && !m;
      d = impulsoDisplay && !m;
      tk = m_mode != 1 && m_pres == CLK - 1;
      if (m_mode != 1 && (m_pres == CLK/2 - 1 || m_pres == CLK - 1)) m_par = !m_par;
      m_pres = (m_mode == 1 || m_pres == CLK - 1) ? 0 : m_pres + 1;
      rol = tk && m_t % 60 == 59;
      if (tk) m_t = (m_t + 1) % 86400;
      if (m_mode == 1) begin
        m_t -= m_t % 60;
        if (a && m_campo == 0) m_t = (m_t / 3600) * 3600 + ((m_t / 60 % 60 + 1) % 60) * 60;
        else if (a) m_t = ((m_t / 3600 + 1) % 24) * 3600 + (m_t / 60 % 60) * 60;
      end
      mt = 0; dis = 0; re = 0;
      for (int k = 0; k < NA; k++) mt[k] = rol && m_hab[k] && m_t / 60 == al[k];
      if (m_mode >= 2 && a) begin
        if (m_campo == 0) al[m_mode-2] = al[m_mode-2] / 60 * 60 + (al[m_mode-2] % 60 + 1) % 60;
        else if (m_campo == 1) al[m_mode-2] = ((al[m_mode-2] / 60 + 1) % 24) * 60 + al[m_mode-2] % 60;
        else begin
          dis[m_mode-2] = m_hab[m_mode-2];
          m_hab[m_mode-2] = !m_hab[m_mode-2];
        end
      end
      sil = m_mode == 0 && a;
`ifdef RELOJ_SNOOZE_EN
      if (sil && m_son != 0) begin
        m_mask = m_son;
        m_snz = SNZ;
      end else begin
        if (rol && m_snz > 0) begin
          m_snz--;
          if (m_snz == 0) begin
            re = m_mask & m_hab;
            m_mask = 0;
          end
        end
        m_mask &= ~dis;
      end
`endif
      if (rol) m_son = mt | re;
      m_son &= ~dis;
      if (sil) m_son = 0;
      if (m) begin
        m_mode = (m_mode + 1) % (NA + 2);
        m_campo = 0;
      end else if (d && m_mode == 1) m_campo ^= 1;
      else if (d && m_mode >= 2) m_campo = (m_campo + 1) % 3;
    end
  end

  always @(negedge clock) chk("cycle", obs, expv());

  task automatic pulse(input logic m, input logic a, input logic d);
    {impulsoModo, impulsoAumentar, impulsoDisplay} = {m, a, d};
    @(negedge clock);
    {impulsoModo, impulsoAumentar, impulsoDisplay} = 3'b000;
  endtask

  task automatic do_reset();
    reset = 1;
    @(negedge clock);
    reset = 0;
  endtask

  task automatic set_alarm1(input int n);
    repeat (3) pulse(1, 0, 0);
    repeat (n) pulse(0, 1, 0);
    repeat (2) pulse(0, 0, 1);
    pulse(0, 1, 0);
    pulse(1, 0, 0);
  endtask

  task automatic wait_time(input string nm, input logic [6:0] mv, input logic [6:0] sv, input int lim);
    int n = 0;
    while ({minutosVista, segundos} !== {mv, sv} && n < lim) begin
      @(negedge clock);
      n++;
    end
    chk(nm, 32'({minutosVista, segundos}), 32'({mv, sv}));
  endtask

  typedef struct {
    logic m, a, d;
    logic [1:0] modo, campo;
    logic [6:0] mv;
  } vec_t;
  vec_t tbl [12];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 7'h00};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 7'h00};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 2'd1, 2'd1, 7'h00};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 7'h00};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 2'd1, 2'd0, 7'h01};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 2'd2, 2'd0, 7'h00};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 2'd2, 2'd1, 7'h00};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 2'd2, 2'd2, 7'h00};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 7'h00};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 2'd2, 2'd0, 7'h01};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 2'd3, 2'd0, 7'h00};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 7'h01};
    @(negedge clock);
    reset = 0;
    chk("reset", obs, 32'd0);
    for (int i = 0; i < 12; i++) begin
      pulse(tbl[i].m, tbl[i].a, tbl[i].d);
      chk($sformatf("tbl%0d", i), 32'({modo, campo, minutosVista}), 32'({tbl[i].modo, tbl[i].campo, tbl[i].mv}));
    end
    // time edit: 61 minute increments wrap to 01 without touching hours
    do_reset();
    pulse(1, 0, 0);
    repeat (61) pulse(0, 1, 0);
    chk("edit", 32'({horasVista, minutosVista, segundos}), 32'({6'h00, 7'h01, 7'h00}));
    pulse(0, 0, 1);
    do_reset();
    chk("reset edit", obs, 32'd0);
    // day rollover from 23:59:59, plus first-tick latency after leaving AJUSTE
    pulse(1, 0, 0);
    pulse(0, 0, 1);
    repeat (23) pulse(0, 1, 0);
    pulse(0, 0, 1);
    repeat (59) pulse(0, 1, 0);
    pulse(1, 0, 0);
    repeat (3) @(negedge clock);
    chk("no early tick", 32'(segundos), 32'h00);
    @(negedge clock);
    chk("first tick", 32'(segundos), 32'h01);
    repeat (2) pulse(1, 0, 0);
    wait_time("reach 59:59", 7'h59, 7'h59, 400);
    chk("hour 23", 32'(horasVista), 32'h23);
    repeat (4) @(negedge clock);
    chk("midnight", 32'({horasVista, minutosVista, segundos}), 32'd0);
    // alarm 1 at 00:02 rings for exactly one minute
    do_reset();
    set_alarm1(2);
    wait_time("ring at", 7'h02, 7'h00, 600);
    chk("ring set", 32'(sonando), 32'(2'b10));
    wait_time("ring end at", 7'h03, 7'h00, 300);
    chk("ring clr", 32'(sonando), 32'(2'b00));
    // silence at 00:01:10, snooze (if built in) brings it back at 00:03:00
    do_reset();
    set_alarm1(1);
    wait_time("ring1 at", 7'h01, 7'h00, 300);
    chk("ring1 set", 32'(sonando), 32'(2'b10));
    wait_time("silence at", 7'h01, 7'h10, 60);
    pulse(0, 1, 0);
    chk("silence", 32'(sonando), 32'(2'b00));
    wait_time("snooze at", 7'h03, 7'h00, 500);
    chk("snooze", 32'(sonando), 32'(SNZ_EXP));
    // reset while ringing
    do_reset();
    set_alarm1(1);
    wait_time("ring2 at", 7'h01, 7'h00, 300);
    chk("ring2 set", 32'(sonando), 32'(2'b10));
    do_reset();
    chk("reset ring", obs, 32'd0);
    // random pulses against the model
    repeat (3000) begin
      impulsoModo = $urandom_range(31) == 0;
      impulsoAumentar = $urandom_range(3) == 0;
      impulsoDisplay = $urandom_range(7) == 0;
      @(negedge clock);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end
endmodule

// File: doc/reloj_digital_param.md
# reloj_digital_param

Parametrised digital-clock core: BCD time-of-day counters (HH:MM:SS, 24 h), a mode FSM for setting the time and up to `NUM_ALARMS` independent alarms, per-alarm enable, and registered "ringing" flags. It sits between the button front-end (debounce plus pulse generation, already single-cycle) and the display/LED encoders. It replaces the fixed one-alarm clock chain and adds several alarms, enable bits, auto-clear and optional snooze.

## Interface
- `CLK_HZ`, default 50_000_000: `clock` cycles per second; must be ≥ 4 and even.
- `NUM_ALARMS`, default 2: number of alarms, 1–4.
- `SNOOZE_MIN`, default 5: snooze delay in minutes, 1–59; used only with snooze compiled in.
- `clock`, in, 1: single system clock, rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `impulsoModo`, in, 1: one-cycle pulse; advance mode.
- `impulsoAumentar`, in, 1: one-cycle pulse; increment field, toggle enable, or silence.
- `impulsoDisplay`, in, 1: one-cycle pulse; select next field.
- `modo`, out, `$clog2(NUM_ALARMS+2)`: current mode.
- `campo`, out, 2: field being edited (0 = min, 1 = hour, 2 = enable).
- `horasVista`, out, 6: BCD hours shown, tens in [5:4], units in [3:0].
- `minutosVista`, out, 7: BCD minutes shown, tens in [6:4], units in [3:0].
- `segundos`, out, 7: BCD seconds of the time of day.
- `habilitada`, out, `NUM_ALARMS`: per-alarm enable.
- `sonando`, out, `NUM_ALARMS`: per-alarm ringing flag.
- `parpadeo`, out, 1: 1 Hz square wave for the blinking edit field and the seconds dot.
- Clock and reset: one clock; reset is synchronous and active-high.

## Operation
- Prescaler `0..CLK_HZ-1`. `tick` is asserted for one cycle at `CLK_HZ-1`. `parpadeo` toggles at `CLK_HZ/2-1` and at `CLK_HZ-1`.
- Time counters roll over 59 s → 00 (carry to minutes), 59 min → 00 (carry to hours), 23 h → 00. Digits are always legal BCD.
- Modes: `RELOJ` (0) → `AJUSTE` (1) → `ALARMA_0` … `ALARMA_{N-1}` → `RELOJ`. Each `impulsoModo` advances one step. `campo` is forced to 0 on every mode change.
- `RELOJ`:
  - `impulsoDisplay` is ignored.
  - `impulsoAumentar` clears all `sonando` bits.
- `AJUSTE`:
  - The prescaler and seconds are held at 0; there are no ticks.
  - `impulsoDisplay` toggles `campo` between 0 and 1.
  - `impulsoAumentar` increments the selected field modulo 60 (minutes) or 24 (hours), with no carry between fields.
- `ALARMA_k`:
  - Time keeps running.
  - `campo` cycles 0 → 1 → 2 → 0.
  - `impulsoAumentar` increments alarm k's minutes or hours (same modulo, no carry), or toggles `habilitada[k]` when `campo` is 2.
- View mux (combinational from registers): `RELOJ` and `AJUSTE` show the time; `ALARMA_k` shows alarm k.
- Match:
  - On a `tick` that rolls the seconds to 00, `sonando[k]` is set if `habilitada[k]` and the new HH:MM equals alarm k.
  - `sonando[k]` clears automatically on the next minute rollover, when clearing `habilitada[k]`, or via `impulsoAumentar` in `RELOJ`.
  - Changing the time in `AJUSTE` never triggers a match.
- Simultaneous events:
  - `impulsoModo` has priority: other pulses in that cycle are dropped.
  - A tick carry and an alarm-field increment in the same cycle both take effect.
  - A match set and a silence in the same cycle: silence wins.

## Timing
- Reset values:
  - Time 00:00:00 and all alarms 00:00.
  - `habilitada`, `sonando`, `parpadeo` = 0.
  - `modo` = `RELOJ`, `campo` = 0, prescaler = 0.
- All state is registered. An input pulse at edge n is visible on outputs after edge n.
- `sonando` rises on the same edge as the seconds → 00 transition.
- The first `tick` occurs `CLK_HZ` cycles after reset is released, or after leaving `AJUSTE`.
- Asserting `reset` mid-edit or mid-ring returns everything to the reset values on the next edge.

## Configuration
- `RELOJ_SNOOZE_EN` defined:
  - `impulsoAumentar` in `RELOJ` while any `sonando` bit is set copies `sonando` to a snooze mask, clears `sonando`, and loads a minute counter with `SNOOZE_MIN`.
  - The counter decrements on each minute rollover. When it reaches 0, masked bits whose alarm is still enabled re-assert `sonando`, and the mask clears.
  - A new match ORs into `sonando` independently.
  - Disabling alarm k removes it from the mask.
- `RELOJ_SNOOZE_EN` undefined: silencing is final, with no snooze logic or registers.

## Structure
- Package `reloj_pkg`:
  - Mode constants `MODO_RELOJ`, `MODO_AJUSTE`, `MODO_ALARMA0`.
  - Field constants `CAMPO_MIN`, `CAMPO_HOR`, `CAMPO_HAB`.
  - BCD limit constants (59, 23).
  - Function `bcd_inc(value, max)`.
- One sub-module, `contador_bcd_mod`: a modulo-N two-digit BCD counter with `inc`, `clr` and carry-out. It is instantiated for seconds, minutes and hours, and per alarm for minutes and hours.

## Test plan
- Time rollover (`CLK_HZ=4`): reset, run 86 400 ticks → time returns to 00:00:00. At 23:59:59 plus one tick → 00:00:00.
- Time edit: `impulsoModo` once, `impulsoAumentar` ×61 on minutes → minutes = 01, hours unchanged, seconds held at 00.
- Alarm edit and ring:
  - In `ALARMA_1`, set 00:02 and enable it; return to `RELOJ` → `sonando[1]` rises exactly at time 00:02:00.
  - `sonando[1]` clears at 00:03:00, and `sonando[0]` stays 0.
- Silence and priority:
  - While ringing, `impulsoAumentar` in `RELOJ` → `sonando` = 0 on the next edge.
  - `impulsoModo` and `impulsoAumentar` in the same cycle in `AJUSTE` → mode advances and the field is unchanged.
- Snooze (`RELOJ_SNOOZE_EN`, `SNOOZE_MIN=2`): alarm at 00:01, silenced at 00:01:10 → `sonando` re-asserts at 00:03:00.
- Reset mid-ring and mid-edit → all outputs at reset values on the next edge.
